// File: rtl/reg_file_mp_pkg.sv
// Shared constants, elaboration helpers and bus typedefs for the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int ZERO_REG       = 0;
  localparam int MAX_RD         = 4;

  // Packed read-address bus sized for the largest supported port count.
  typedef logic [MAX_RD-1:0][DEFAULT_ADDR_W-1:0] rd_addr_bus_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Register-file access bus: two write ports, packed read ports, busy scoreboard issue.
// Handshake: no valid/ready. WRITEn and BUSY_SET are single-cycle qualifiers sampled
// at the rising clock edge; reads are combinational and have no qualifier.
interface reg_file_mp_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [WIDTH-1:0]         IN0;
  logic [ADDR_W-1:0]        INADDRESS0;
  logic                     WRITE0;
  logic [WIDTH-1:0]         IN1;
  logic [ADDR_W-1:0]        INADDRESS1;
  logic                     WRITE1;
  logic [NUM_RD*ADDR_W-1:0] OUTADDRESS;
  logic [NUM_RD*WIDTH-1:0]  OUT;
  logic [NUM_RD-1:0]        BUSY;
  logic                     BUSY_SET;
  logic [ADDR_W-1:0]        BUSY_SET_ADDRESS;

  modport master (
    output IN0, INADDRESS0, WRITE0, IN1, INADDRESS1, WRITE1,
    output OUTADDRESS, BUSY_SET, BUSY_SET_ADDRESS,
    input  OUT, BUSY
  );

  modport slave (
    input  IN0, INADDRESS0, WRITE0, IN1, INADDRESS1, WRITE1,
    input  OUTADDRESS, BUSY_SET, BUSY_SET_ADDRESS,
    output OUT, BUSY
  );
endinterface

// File: rtl/reg_file_mp_rd_port.sv
// One combinational read port: x0 forcing, write bypass (port 1 over port 0), busy lookup.
module reg_file_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [WIDTH-1:0]  regs_i [DEPTH],
  input  logic [DEPTH-1:0]  busy_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [WIDTH-1:0]  wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [WIDTH-1:0]  wdata1_i,
  output logic [WIDTH-1:0]  data_o,
  output logic              busy_o
);

  always_comb begin
    data_o = '0;
    if (addr_i != ADDR_W'(ZERO_REG)) begin
      if (we1_i && (waddr1_i == addr_i))      data_o = wdata1_i;
      else if (we0_i && (waddr0_i == addr_i)) data_o = wdata0_i;
      else                                    data_o = regs_i[addr_i];
    end
  end

  // Busy is deliberately not bypassed: an in-flight write still stalls decode this cycle.
  assign busy_o = busy_i[addr_i];

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with dual write ports, read bypass and a pending-write scoreboard.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_mp_if.slave bus
);

  if (ADDR_W != clog2(DEPTH)) begin : g_bad_addr_w
    $error("reg_file_mp: ADDR_W must equal clog2(DEPTH)");
  end

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]        busy_q;
  logic [DEPTH-1:0]        busy_d;
  logic                    commit0;
  logic                    commit1;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;

  assign commit0 = bus.WRITE0 && (bus.INADDRESS0 != ADDR_W'(ZERO_REG));
  assign commit1 = bus.WRITE1 && (bus.INADDRESS1 != ADDR_W'(ZERO_REG));

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    mem_d = mem_q;
    if (commit0) mem_d[bus.INADDRESS0] = bus.IN0;
    if (commit1) mem_d[bus.INADDRESS1] = bus.IN1;
    mem_d[ZERO_REG] = '0;
  end

  // A new issue is younger than any completing write, so set overrides clear.
  always_comb begin
    busy_d = busy_q;
    if (commit0) busy_d[bus.INADDRESS0] = 1'b0;
    if (commit1) busy_d[bus.INADDRESS1] = 1'b0;
    if (bus.BUSY_SET && (bus.BUSY_SET_ADDRESS != ADDR_W'(ZERO_REG)))
      busy_d[bus.BUSY_SET_ADDRESS] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_rd_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_rd (
      .regs_i  (mem_q),
      .busy_i  (busy_q),
      .addr_i  (bus.OUTADDRESS[k*ADDR_W +: ADDR_W]),
      .we0_i   (bus.WRITE0),
      .waddr0_i(bus.INADDRESS0),
      .wdata0_i(bus.IN0),
      .we1_i   (bus.WRITE1),
      .waddr1_i(bus.INADDRESS1),
      .wdata1_i(bus.IN1),
      .data_o  (rd_data[k*WIDTH +: WIDTH]),
      .busy_o  (rd_busy[k])
    );
  end

  assign bus.OUT  = rd_data;
  assign bus.BUSY = rd_busy;

endmodule
